// File: rtl/arbiter_request_queues.sv
// rtl/arbiter_request_queues.sv - three client FIFOs feeding a priority arbiter, popped onto one shared port
module arbiter_request_queues #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_0,
  input  logic                  push_1,
  input  logic                  push_2,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic                  full_0,
  output logic                  full_1,
  output logic                  full_2,
  output logic                  req_0,
  output logic                  req_1,
  output logic                  req_2,
  input  logic                  gnt_0,
  input  logic                  gnt_1,
  input  logic                  gnt_2,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            src_out,
  output logic                  overflow,
  output logic                  grant_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [3][DEPTH];
  logic [AW-1:0]         wptr_q [3], wptr_d [3];
  logic [AW-1:0]         rptr_q [3], rptr_d [3];
  logic [AW:0]           count_q [3], count_d [3];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            src_out_q, src_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  overflow_q, overflow_d;
  logic                  grant_err_q, grant_err_d;

  logic [DATA_WIDTH-1:0] din [3];
  logic [2:0]            push, gnt, pop, push_ok;
  logic                  multi_gnt;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign push   = {push_2, push_1, push_0};
  assign gnt    = {gnt_2, gnt_1, gnt_0};
  // A set bit survives clearing the lowest set bit only if two or more were set.
  assign multi_gnt = (gnt & (gnt - 3'd1)) != 3'd0;

  always_comb begin
    overflow_d  = overflow_q;
    grant_err_d = grant_err_q | multi_gnt;
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    src_out_d   = src_out_q;
    for (int k = 0; k < 3; k++) begin
      pop[k]     = gnt[k] && !multi_gnt && (count_q[k] != '0);
      // A pop in the same cycle frees the slot, so a push on a full queue still lands.
      push_ok[k] = push[k] && ((count_q[k] != FULL_CNT) || pop[k]);
      if (push[k] && !push_ok[k]) overflow_d = 1'b1;
      wptr_d[k]  = push_ok[k] ? wptr_q[k] + 1'b1 : wptr_q[k];
      rptr_d[k]  = pop[k] ? rptr_q[k] + 1'b1 : rptr_q[k];
      count_d[k] = count_q[k];
      if (push_ok[k] && !pop[k]) count_d[k] = count_q[k] + 1'b1;
      else if (!push_ok[k] && pop[k]) count_d[k] = count_q[k] - 1'b1;
      if (pop[k]) begin
        valid_out_d = 1'b1;
        data_out_d  = mem_q[k][rptr_q[k]];
        src_out_d   = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        wptr_q[k]  <= '0;
        rptr_q[k]  <= '0;
        count_q[k] <= '0;
      end
      data_out_q  <= '0;
      src_out_q   <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        wptr_q[k]  <= wptr_d[k];
        rptr_q[k]  <= rptr_d[k];
        count_q[k] <= count_d[k];
      end
      data_out_q  <= data_out_d;
      src_out_q   <= src_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      grant_err_q <= grant_err_d;
    end
  end

  // Storage is intentionally unreset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (push_ok[k]) mem_q[k][wptr_q[k]] <= din[k];
  end

  assign req_0     = count_q[0] != '0;
  assign req_1     = count_q[1] != '0;
  assign req_2     = count_q[2] != '0;
  assign full_0    = count_q[0] == FULL_CNT;
  assign full_1    = count_q[1] == FULL_CNT;
  assign full_2    = count_q[2] == FULL_CNT;
  assign data_out  = data_out_q;
  assign src_out   = src_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign grant_err = grant_err_q;
endmodule

// File: tb/tb_arbiter_request_queues.sv
// tb/tb_arbiter_request_queues.sv - scoreboard bench for arbiter_request_queues
module tb_arbiter_request_queues;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_0 = 0, push_1 = 0, push_2 = 0;
  logic [7:0] data_in_0 = 0, data_in_1 = 0, data_in_2 = 0;
  logic       gnt_0 = 0, gnt_1 = 0, gnt_2 = 0;
  logic       full_0, full_1, full_2, req_0, req_1, req_2;
  logic [7:0] data_out;
  logic       valid_out, overflow, grant_err;
  logic [1:0] src_out;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb [$];

  arbiter_request_queues #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .push_0(push_0), .push_1(push_1), .push_2(push_2),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .req_0(req_0), .req_1(req_1), .req_2(req_2),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .overflow(overflow), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && valid_out) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got src=%0d data=%h, none expected", src_out, data_out);
      end else begin
        logic [9:0] exp;
        exp = sb.pop_front();
        if ({src_out, data_out} !== exp) begin
          errors++;
          $display("FAIL pop_data: got src=%0d data=%h, expected src=%0d data=%h",
                   src_out, data_out, exp[9:8], exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    push_0 = 0; push_1 = 0; push_2 = 0;
    gnt_0 = 0; gnt_1 = 0; gnt_2 = 0;
  endtask

  task automatic expect_pop(input logic [1:0] src, input logic [7:0] d);
    sb.push_back({src, d});
  endtask

  task automatic do_reset();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  initial begin
    // Reset then idle
    step();
    step();
    rst = 1;
    step();
    chk("idle_req", {req_2, req_1, req_0}, 3'b000);
    chk("idle_full", {full_2, full_1, full_0}, 3'b000);
    chk("idle_valid", valid_out, 1'b0);
    chk("idle_data", data_out, 8'h00);
    chk("idle_src", src_out, 2'd0);
    chk("idle_ovf", overflow, 1'b0);
    chk("idle_gerr", grant_err, 1'b0);

    // Fill queue 0 past capacity
    for (int i = 0; i < 5; i++) begin
      push_0 = 1; data_in_0 = 8'h11 + 8'(i);
      step();
      if (i == 0) chk("req0_after_push", req_0, 1'b1);
      if (i == 2) chk("full0_at_3", full_0, 1'b0);
      if (i == 3) chk("full0_at_4", full_0, 1'b1);
      if (i == 3) chk("ovf_at_4", overflow, 1'b0);
      if (i == 4) chk("ovf_at_5", overflow, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      gnt_0 = 1;
      expect_pop(2'd0, 8'h11 + 8'(i));
      step();
    end
    chk("req0_drained", req_0, 1'b0);
    chk("full0_drained", full_0, 1'b0);
    gnt_0 = 1;
    step();
    chk("lost_word_no_pop", valid_out, 1'b0);
    do_reset();
    chk("ovf_cleared", overflow, 1'b0);

    // Pointer wrap on queue 1
    for (int i = 0; i < 10; i++) begin
      push_1 = 1; data_in_1 = 8'hA0 + 8'(i);
      step();
      gnt_1 = 1;
      expect_pop(2'd1, 8'hA0 + 8'(i));
      step();
    end
    step();
    chk("req1_after_wrap", req_1, 1'b0);

    // Push and pop together on full queue 2
    for (int i = 0; i < 4; i++) begin
      push_2 = 1; data_in_2 = 8'h21 + 8'(i);
      step();
    end
    chk("full2_loaded", full_2, 1'b1);
    push_2 = 1; data_in_2 = 8'h25; gnt_2 = 1;
    expect_pop(2'd2, 8'h21);
    step();
    chk("full2_after_pp", full_2, 1'b1);
    chk("ovf_after_pp", overflow, 1'b0);
    chk("valid_after_pp", valid_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      gnt_2 = 1;
      expect_pop(2'd2, 8'h22 + 8'(i));
      step();
    end
    chk("req2_drained", req_2, 1'b0);

    // Grant on empty, then multi-hot grant
    gnt_0 = 1;
    step();
    chk("empty_gnt_valid", valid_out, 1'b0);
    chk("empty_gnt_gerr", grant_err, 1'b0);
    push_0 = 1; data_in_0 = 8'h31; push_1 = 1; data_in_1 = 8'h41;
    step();
    gnt_0 = 1; gnt_1 = 1;
    step();
    chk("multi_valid", valid_out, 1'b0);
    chk("multi_gerr", grant_err, 1'b1);
    chk("multi_req", {req_1, req_0}, 2'b11);
    gnt_0 = 1;
    expect_pop(2'd0, 8'h31);
    step();
    chk("req0_one_entry", req_0, 1'b0);
    gnt_1 = 1;
    expect_pop(2'd1, 8'h41);
    step();
    chk("req1_one_entry", req_1, 1'b0);
    step();
    chk("gerr_sticky", grant_err, 1'b1);

    // Reset mid-burst
    for (int i = 0; i < 3; i++) begin
      push_0 = 1; push_1 = 1; push_2 = 1;
      data_in_0 = 8'h50 + 8'(i); data_in_1 = 8'h60 + 8'(i); data_in_2 = 8'h70 + 8'(i);
      step();
    end
    chk("burst_req", {req_2, req_1, req_0}, 3'b111);
    #2;
    rst = 0;
    #1;
    chk("rst_req_immediate", {req_2, req_1, req_0}, 3'b000);
    chk("rst_gerr", grant_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1;
    push_1 = 1; data_in_1 = 8'h7E;
    step();
    chk("req1_after_rst", {req_2, req_1, req_0}, 3'b010);
    gnt_1 = 1;
    expect_pop(2'd1, 8'h7E);
    step();
    chk("rst_pop_data", data_out, 8'h7E);
    chk("rst_pop_src", src_out, 2'd1);
    step();
    step();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_request_queues.md
# arbiter_request_queues

Three independent request FIFOs that sit directly upstream of the three-input priority arbiter. Each client pushes data words into its own queue. A non-empty queue raises its request line toward the arbiter. A grant from the arbiter pops that queue's head onto a single shared output port with a one-cycle valid strobe. This turns per-client bursts into arbitrated, serialized traffic for the downstream consumer.

## Interface
- DATA_WIDTH, 8, width of every data word
- DEPTH, 4, entries per queue; power of two, minimum 2
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous, active-low reset
- push_0, push_1, push_2  input  1 each  client n writes data_in_n this cycle
- data_in_0, data_in_1, data_in_2  input  DATA_WIDTH each  client n write data
- full_0, full_1, full_2  output  1 each  queue n holds DEPTH entries
- req_0, req_1, req_2  output  1 each  queue n non-empty; wired to arbiter req_n
- gnt_0, gnt_1, gnt_2  input  1 each  arbiter grant; wired from arbiter gnt_n
- data_out  output  DATA_WIDTH  head word popped on the previous edge
- valid_out  output  1  data_out is new this cycle, one-cycle pulse
- src_out  output  2  queue index (0..2) that produced data_out
- overflow  output  1  sticky: push attempted on a full queue
- grant_err  output  1  sticky: more than one gnt_n high in the same cycle

## Operation
- Per queue: circular buffer with DEPTH entries. Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- Flags are decoded from the registered count, so there is no combinational path from any input:
  - req_n = (count_n != 0)
  - full_n = (count_n == DEPTH)
- Push:
  - When push_n=1 and the queue is not full, data_in_n is written at wptr_n and wptr_n increments.
  - When push_n=1 on a full queue with no pop in the same cycle, the word is dropped, pointers are unchanged, and overflow is set.
- Pop:
  - Happens when gnt_n=1, count_n>0, and exactly one gnt is high.
  - On a pop: data_out <= mem_n[rptr_n], src_out <= n, valid_out <= 1, rptr_n increments.
- Grant on an empty queue:
  - Expected, because the arbiter's registered grant lags its request by one cycle.
  - It is silently ignored: no pop, valid_out=0, no error.
- Multi-hot grant (two or more gnt_n high):
  - No queue pops and valid_out=0 that cycle.
  - grant_err is set.
- Simultaneous push and pop on the same queue:
  - Both take effect and count is unchanged.
  - This includes the full case: the pop frees a slot, so the push is accepted and overflow is not set.
  - It also includes count=1: the head pops and the new word is stored.
- Push on an empty queue while its gnt is high: the push is accepted and the grant is ignored.
- overflow and grant_err clear only on reset.
- When no pop occurs, data_out and src_out hold their last values.

## Timing
- Reset (rst=0, asynchronous assert, synchronous release on clk):
  - All counts, pointers, valid_out, overflow, grant_err, and src_out are 0.
  - data_out is 0.
  - Therefore req_n=0 and full_n=0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all queued words immediately. The first edge after release behaves as an empty start.
- Push at edge t: count updates at t, and req_n rises in the cycle after edge t.
- Grant sampled at edge t: valid_out, data_out, and src_out are valid for the cycle following edge t (latency 1). The count decrement also happens at t.
- Throughput: one pop per cycle total, and one push per cycle per queue.
- With the priority arbiter attached, a single-entry queue sees its grant one cycle after req rises. It may see one trailing grant after emptying; that grant is ignored as specified.

## Test plan
- Reset then idle:
  - Stimulus: rst low for 2 cycles, then release with no push.
  - Required: all req_n=0, full_n=0, valid_out=0, data_out=0, overflow=0, grant_err=0.
- Fill and overflow:
  - Stimulus: 5 pushes of 0x11..0x15 to queue 0 with DEPTH=4 and no grant.
  - Required: full_0=1 after the 4th push, overflow=1 after the 5th, 0x15 is lost.
  - Follow-up: grant queue 0 for 4 cycles. Required: valid_out pulses in order with data 0x11, 0x12, 0x13, 0x14, src_out=0, req_0 ends at 0.
- Pointer wrap:
  - Stimulus: 10 push/pop pairs of 0xA0..0xA9 through queue 1, interleaved so count stays at or below 2.
  - Required: outputs are 0xA0..0xA9 in order and src_out=1.
- Simultaneous push and pop on a full queue:
  - Stimulus: queue 2 full with 0x21..0x24; in one cycle push 0x25 and gnt_2=1.
  - Required: valid_out with 0x21, full_2 stays 1, overflow stays 0; a later drain yields 0x22..0x25.
- Grant on empty, and multi-hot grant:
  - Stimulus: gnt_0=1 with queue 0 empty.
  - Required: valid_out=0, grant_err=0.
  - Stimulus: queues 0 and 1 loaded, gnt_0=gnt_1=1 for one cycle.
  - Required: no pop, both counts unchanged, grant_err=1 until reset.
- Reset mid-burst:
  - Stimulus: 3 entries in each queue, assert rst for 1 cycle between edges.
  - Required: req_n drop to 0 immediately, and after release a single push of 0x7E to queue 1 followed by gnt_1 yields data_out=0x7E, src_out=1.
